// File: rtl/signed_divider.sv
// Signed 16-bit by 8-bit sequential divider.
// Restoring division on magnitudes, one quotient bit per clock, followed by a
// sign/saturation fix-up cycle. Truncating semantics: the remainder takes the
// dividend's sign. Flags report divide-by-zero and 8-bit quotient overflow.
module signed_divider (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] A,
    input  logic [7:0]  B,
    output logic [7:0]  Quotient,
    output logic [7:0]  Remainder,
    output logic        ready,
    output logic        dbz,
    output logic        ovf
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DIVIDE = 2'd1;
    localparam logic [1:0] FIXUP  = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [15:0] r_dividend;
    logic [7:0]  r_partRem;
    logic [15:0] r_quo;
    logic [8:0]  r_divisor;
    logic        r_signQ;
    logic        r_signR;
    logic [7:0]  r_quotient;
    logic [7:0]  r_remainder;
    logic        r_dbz;
    logic        r_ovf;

    // |A| as 16-bit unsigned: -32768 negates to 16'h8000, which read unsigned is 32768
    logic [15:0] w_absA;
    // |B| in 9 bits so that -128 becomes +128
    logic [8:0]  w_absB;
    logic [8:0]  w_shifted;
    logic        w_qBit;
    logic [7:0]  w_diff;
    logic        w_ovf;
    logic [7:0]  w_qFixed;
    logic [7:0]  w_rFixed;

    assign w_absA    = A[15] ? (16'd0 - A) : A;
    assign w_absB    = B[7] ? (9'd0 - {B[7], B}) : {1'b0, B};

    // The partial remainder is always below |B| <= 128, so after the shift it
    // fits in 9 bits and any accepted difference fits back into 8 bits.
    assign w_shifted = {r_partRem, r_dividend[15]};
    assign w_qBit    = (w_shifted >= r_divisor);
    assign w_diff    = w_shifted[7:0] - r_divisor[7:0];

    // A negative quotient may reach -128, a positive one only +127
    assign w_ovf     = r_signQ ? (r_quo > 16'd128) : (r_quo > 16'd127);
    assign w_qFixed  = w_ovf ? (r_signQ ? 8'h80 : 8'h7F)
                             : (r_signQ ? (8'd0 - r_quo[7:0]) : r_quo[7:0]);
    assign w_rFixed  = r_signR ? (8'd0 - r_partRem) : r_partRem;

    // Control FSM and datapath: start always wins, DIVIDE runs 16 steps, FIXUP applies signs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_dividend  <= 16'd0;
            r_partRem   <= 8'd0;
            r_quo       <= 16'd0;
            r_divisor   <= 9'd0;
            r_signQ     <= 1'b0;
            r_signR     <= 1'b0;
            r_quotient  <= 8'h00;
            r_remainder <= 8'h00;
            r_dbz       <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (start) begin
            r_cnt      <= 4'd0;
            r_dividend <= w_absA;
            r_partRem  <= 8'd0;
            r_quo      <= 16'd0;
            r_divisor  <= w_absB;
            r_signQ    <= A[15] ^ B[7];
            r_signR    <= A[15];
            r_ovf      <= 1'b0;
            if (B == 8'd0) begin
                // Divide by zero: results are final now, FIXUP only holds ready low one cycle
                r_dbz       <= 1'b1;
                r_quotient  <= 8'h00;
                r_remainder <= 8'h00;
                r_state     <= FIXUP;
            end else begin
                r_dbz   <= 1'b0;
                r_state <= DIVIDE;
            end
        end else begin
            case (r_state)
                DIVIDE: begin
                    r_dividend <= {r_dividend[14:0], 1'b0};
                    r_quo      <= {r_quo[14:0], w_qBit};
                    r_partRem  <= w_qBit ? w_diff : w_shifted[7:0];
                    if (r_cnt == 4'd15) begin
                        r_cnt   <= 4'd0;
                        r_state <= FIXUP;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                FIXUP: begin
                    if (!r_dbz) begin
                        r_quotient  <= w_qFixed;
                        r_remainder <= w_rFixed;
                        r_ovf       <= w_ovf;
                    end
                    r_state <= DONE;
                end
                default: r_state <= r_state;
            endcase
        end
    end

    assign ready     = (r_state == IDLE) || (r_state == DONE);
    assign Quotient  = r_quotient;
    assign Remainder = r_remainder;
    assign dbz       = r_dbz;
    assign ovf       = r_ovf;

endmodule
